// File: rtl/datachk.sv
// datachk: AXI-Stream slave frame receiver/checker.
// Stores 8-bit beats into a 256-entry buffer and checks where tlast lands
// against frame_size. Each completed frame is held for register readback
// until software pulses clr, then reception re-arms.
// Optional feature macro: DATACHK_SEQ_CHECK_EN (incrementing-data check,
// reported on err_seq). When it is undefined, err_seq is tied low.
module datachk #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en_recv,
  input  logic [ADDR_W-1:0] frame_size,
  input  logic              clr,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic [ADDR_W:0]   rx_len,
  output logic [15:0]       frame_cnt,
  output logic              err_len,
  output logic              err_seq,
  output logic [1:0]        debug_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rx_len_q, rx_len_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                done_q, done_d;
  logic                err_len_q, err_len_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                wr_en;
  logic                beat;
  logic                at_last;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

`ifdef DATACHK_SEQ_CHECK_EN
  logic                err_seq_q, err_seq_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [DATA_W-1:0]   seq_exp;
`endif

  assign beat    = s_axis_tvalid && s_axis_tready;
  assign at_last = (wr_ptr_q == frame_size);

  // State register and all control/status flops, synchronous active-low reset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rx_len_q    <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
      rd_data_q   <= '0;
`ifdef DATACHK_SEQ_CHECK_EN
      err_seq_q   <= 1'b0;
      prev_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rx_len_q    <= rx_len_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
      rd_data_q   <= mem[rd_addr];
`ifdef DATACHK_SEQ_CHECK_EN
      err_seq_q   <= err_seq_d;
      prev_q      <= prev_d;
`endif
    end
  end

  // Frame buffer write port; a same-cycle read of the written address sees old data.
  // NOTE: the buffer is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= s_axis_tdata;
    end
  end

  // Next-state logic: tlast position vs. frame_size decides hold or drain.
  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (en_recv) state_d = S_RECV;
      end
      S_RECV: begin
        if (beat) begin
          if (s_axis_tlast)  state_d = S_HOLD;
          else if (at_last)  state_d = S_DRAIN;
        end else if (wr_ptr_q == '0 && !en_recv) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (beat && s_axis_tlast) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (clr) state_d = en_recv ? S_RECV : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: buffer write, length/frame counters and sticky error flags.
  always_comb begin
    wr_en       = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rx_len_d    = rx_len_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = done_q;
    err_len_d   = err_len_q;
`ifdef DATACHK_SEQ_CHECK_EN
    err_seq_d   = err_seq_q;
    prev_d      = prev_q;
    seq_exp     = prev_q + 1'b1;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (en_recv) begin
          wr_ptr_d = '0;
          rx_len_d = '0;
        end
      end
      S_RECV: begin
        if (beat) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          rx_len_d = rx_len_q + 1'b1;
          if (s_axis_tlast) begin
            done_d = 1'b1;
            if (at_last) frame_cnt_d = frame_cnt_q + 16'd1;
            else         err_len_d   = 1'b1;
          end else if (at_last) begin
            err_len_d = 1'b1;
          end
`ifdef DATACHK_SEQ_CHECK_EN
          // First beat of a frame only seeds the reference value.
          prev_d = s_axis_tdata;
          if (wr_ptr_q != '0 && s_axis_tdata != seq_exp) err_seq_d = 1'b1;
`endif
        end
      end
      S_DRAIN: begin
        if (beat && s_axis_tlast) done_d = 1'b1;
      end
      S_HOLD: begin
        if (clr) begin
          done_d    = 1'b0;
          err_len_d = 1'b0;
          wr_ptr_d  = '0;
          rx_len_d  = '0;
`ifdef DATACHK_SEQ_CHECK_EN
          err_seq_d = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  // Outputs: tready depends only on state, so it never waits on tvalid.
  always_comb begin
    s_axis_tready = (state_q == S_RECV) || (state_q == S_DRAIN);
    debug_state   = state_q;
  end

  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign rx_len    = rx_len_q;
  assign frame_cnt = frame_cnt_q;
  assign err_len   = err_len_q;
`ifdef DATACHK_SEQ_CHECK_EN
  assign err_seq   = err_seq_q;
`else
  assign err_seq   = 1'b0;
`endif

endmodule
